// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 pipeline.
//   INSTR_W, ADDR_W : instruction and address widths
//   NOP_INSTR       : encoding presented on a pipeline bubble
//   fetch_state_t   : fetch-stage state machine encoding
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register.
//   clk, reset_n : clock and synchronous active-low reset
//   flush_i      : load a bubble (valid=0, instr=NOP); pc is left as is
//   hold_i       : keep current contents
//   load_i       : capture instr_i / pc_i as a valid instruction
//   instr_o, pc_o, valid_o : registered contents
// Priority: reset > flush > hold > load; with none asserted the contents hold.
module instruction_fetch_ifid_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic               hold_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (hold_i) begin
            // keep contents
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// PC and fetch stage of the pipelined LEGv8 CPU.
//   clk, reset_n          : clock, synchronous active-low reset
//   stall                 : hold PC and IF/ID
//   br_taken, br_pc,
//   br_offset             : branch redirect; target = br_pc + (br_offset << 2)
//   imem_addr, imem_instr : combinational instruction memory interface
//   ifid_instr, ifid_pc,
//   ifid_valid            : IF/ID pipeline register outputs
//   fetch_fault           : sticky illegal-fetch flag
//   fetch_count           : saturating count of valid instructions delivered
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [ADDR_W-1:0] PcLimit = ADDR_W'(4 * IMEM_WORDS);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       fetch_count_q, fetch_count_d;

    logic [ADDR_W-1:0] br_target;
    logic              pc_illegal;
    logic              ifid_load, ifid_hold, ifid_flush;

    // Offset is in words; wrap-around is intended.
    assign br_target  = br_pc + (br_offset << 2);
    assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q >= PcLimit);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        ifid_load     = 1'b0;
        ifid_hold     = 1'b0;
        ifid_flush    = 1'b0;
        case (state_q)
            FETCH_RUN: begin
                if (br_taken) begin
                    // Squash the wrong-path fetch; an illegal target faults on the next fetch.
                    pc_d       = br_target;
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (pc_illegal) begin
                    state_d    = FETCH_FAULT;
                    ifid_flush = 1'b1;
                end else begin
                    pc_d      = pc_q + 32'd4;
                    ifid_load = 1'b1;
                    if (fetch_count_q != 32'hFFFF_FFFF) begin
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                end
            end
            default: begin
                // Frozen until reset; keep presenting bubbles.
                state_d    = FETCH_FAULT;
                ifid_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= FETCH_RUN;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    instruction_fetch_ifid_reg u_ifid_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (ifid_load),
        .hold_i  (ifid_hold),
        .flush_i (ifid_flush),
        .instr_i (imem_instr),
        .pc_i    (pc_q),
        .instr_o (ifid_instr),
        .pc_o    (ifid_pc),
        .valid_o (ifid_valid)
    );

    assign imem_addr   = pc_q;
    assign fetch_fault = (state_q == FETCH_FAULT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a reference model predicts the state after
// each edge, pushes it into a queue, and a monitor compares after the edge.
module tb_instruction_fetch;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    instruction_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_valid  (ifid_valid),
        .fetch_fault (fetch_fault),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 1024 words; out-of-range reads return junk, never X.
    logic [31:0] mem [1024];
    assign imem_instr = (imem_addr < 32'd4096) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic        fault;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_ipc, m_count;
    logic        m_valid, m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Apply inputs for the coming edge and push the predicted outcome.
    task automatic drive(input logic rst_n, input logic st, input logic br,
                         input logic [31:0] bpc, input logic [31:0] boff);
        exp_t e;
        reset_n   = rst_n;
        stall     = st;
        br_taken  = br;
        br_pc     = bpc;
        br_offset = boff;
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_valid = 1'b0;
            m_fault = 1'b0; m_count = 32'h0;
        end else if (m_fault) begin
            m_valid = 1'b0;
            m_instr = 32'h0;
        end else if (br) begin
            m_pc    = bpc + boff * 4;
            m_valid = 1'b0;
            m_instr = 32'h0;
        end else if (st) begin
            // nothing moves
        end else if (m_pc % 4 == 0 && m_pc < 4 * 1024) begin
            m_instr = mem[m_pc / 4];
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        end else begin
            m_fault = 1'b1;
            m_valid = 1'b0;
            m_instr = 32'h0;
        end
        e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.valid = m_valid;
        e.fault = m_fault; e.count = m_count;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst_n, input logic st, input logic br,
                        input logic [31:0] bpc, input logic [31:0] boff);
        @(negedge clk);
        drive(rst_n, st, br, bpc, boff);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: one expectation per edge once stimulus has started.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("imem_addr", imem_addr, e.pc);
            check("ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
            check("ifid_instr", ifid_instr, e.instr);
            check("fetch_fault", {31'h0, fetch_fault}, {31'h0, e.fault});
            check("fetch_count", fetch_count, e.count);
            if (e.valid) check("ifid_pc", ifid_pc, e.ipc);
        end
    end

    initial begin
        logic        r, s, b;
        logic [31:0] bp, bo;
        int          guard;

        reset_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_pc = '0; br_offset = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h8B02_0020; mem[1] = 32'hCB03_0041;
        mem[2] = 32'hF840_0062; mem[3] = 32'hB400_0083;
        m_pc = '0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_fault = 1'b0; m_count = '0;

        // Reset, then four free-running fetches A..D
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run(4);

        // Stall two cycles at pc=8
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run(2);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        run(2);

        // Branch back to 0 with stall also high: branch wins
        step(1'b1, 1'b1, 1'b1, 32'd8, 32'hFFFF_FFFE);
        run(2);

        // Branch to 4096: bubble, then fault; later branches/stall ignored
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd1024);
        run(2);
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd1);
        step(1'b1, 1'b1, 1'b1, 32'd16, 32'd2);
        run(1);

        // Reset out of FAULT, run, then reset mid-stream
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run(3);
        step(1'b0, 1'b1, 1'b1, 32'd40, 32'd3);
        run(2);

        // Misaligned branch target faults on the next fetch
        step(1'b1, 1'b0, 1'b1, 32'd2, 32'd4);
        run(2);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        run(1);

        // Count saturation: preload near the top, then three fetches
        @(negedge clk);
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count_q;
        m_count = 32'hFFFF_FFFE;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        run(2);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            r  = !(($urandom_range(0, 99) < 3) || (m_fault && $urandom_range(0, 99) < 20));
            s  = ($urandom_range(0, 99) < 25);
            b  = ($urandom_range(0, 99) < 12);
            bp = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023)) * 4;
            bo = ($urandom_range(0, 15) == 0) ? $urandom
                                              : 32'($signed($urandom_range(0, 128)) - 64);
            step(r, s, b, bp, bo);
        end

        // Drain the scoreboard within a bounded number of cycles
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- PC and fetch stage of the pipelined LEGv8 CPU.
- Holds the program counter and drives `imem_addr` into the combinational instruction memory (1024 x 32-bit words, 1000 ps output delay).
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles branch redirect/flush, hazard stall and misaligned/out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in words; legal byte addresses are 0 .. 4*IMEM_WORDS-4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- br_taken  in  1  EX stage: branch resolved taken this cycle.
- br_pc  in  32  byte address of the resolving branch instruction.
- br_offset  in  32  sign-extended word offset (imm26/imm19, already extended).
- imem_addr  out  32  byte address to instruction memory; equals pc.
- imem_instr  in  32  instruction word returned by memory.
- ifid_instr  out  32  registered instruction to decode.
- ifid_pc  out  32  registered PC of ifid_instr.
- ifid_valid  out  1  ifid_instr is a real instruction (0 = bubble).
- fetch_fault  out  1  sticky: a fetch was attempted at an illegal PC.
- fetch_count  out  32  saturating count of instructions delivered with valid=1.

Behaviour:
- Clock period must exceed the memory delay plus setup time. imem_addr is combinational from the pc register. imem_instr is sampled at the next rising edge (1-cycle fetch latency).
- br_target = br_pc + (br_offset << 2), 32-bit wrap-around arithmetic, computed combinationally inside the block.
- Illegal PC: pc[1:0] != 0, or pc >= 4*IMEM_WORDS.
- State machine: RUN, FAULT.
- Reset (reset_n=0 at an edge), from any state, mid-operation included:
  - pc=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_valid=0.
  - fetch_fault=0, fetch_count=0, state=RUN.
- Priority each edge in RUN: reset > br_taken > stall > normal.
- br_taken:
  - pc <= br_target.
  - ifid_valid <= 0 and ifid_instr <= 0 (the wrong-path fetch is squashed).
  - Overrides a simultaneous stall.
  - fetch_count unchanged.
- stall (br_taken=0): pc, ifid_instr, ifid_pc, ifid_valid and fetch_count all hold.
- Normal in RUN, pc legal:
  - ifid_instr <= imem_instr, ifid_pc <= pc, ifid_valid <= 1.
  - pc <= pc+4.
  - fetch_count <= fetch_count+1, saturating at 32'hFFFF_FFFF.
- Normal in RUN, pc illegal:
  - state <= FAULT, fetch_fault <= 1.
  - ifid_valid <= 0, ifid_instr <= 0.
  - pc holds.
- FAULT:
  - pc frozen; ifid_valid=0; fetch_fault=1; fetch_count holds.
  - br_taken and stall are ignored.
  - Only reset exits FAULT.
- A branch to an illegal target is accepted. The fault is raised on the following non-stalled edge, when the fetch is attempted.
- pc+4 wrap at 32'hFFFF_FFFC is moot because it is out of range and faults first.
- No X may propagate to ifid_* outputs after reset. A bubble always presents instruction 0.

Decomposition:
- Shared package cpu_pkg:
  - Constants INSTR_W=32, ADDR_W=32, NOP_INSTR=32'h0.
  - enum fetch_state_t {FETCH_RUN, FETCH_FAULT}.
- One natural sub-module: ifid_reg. It holds the IF/ID pipeline register, with inputs for load, hold, flush and reset, and outputs instr, pc and valid. Hazard/forwarding logic stays outside.

Test Plan:
- Reset then 4 free-running cycles (memory holding words A,B,C,D at 0,4,8,12) -> ifid_pc = 0,4,8,12 with ifid_instr = A,B,C,D on successive cycles; ifid_valid=1; fetch_count=4.
- stall held 2 cycles while pc=8 -> pc stays 8; ifid_pc stays 4; fetch_count unchanged; on release ifid_pc=8.
- br_taken with br_pc=8, br_offset=-2 (32'hFFFF_FFFE), with stall also high -> next edge pc=0, ifid_valid=0; the edge after gives ifid_pc=0, ifid_instr=A.
- Branch to br_pc=0, br_offset=1024 (target 4096) -> bubble, then fetch_fault=1 and state FAULT. pc stays 4096 despite later br_taken pulses; ifid_valid stays 0.
- reset_n=0 for one edge while in FAULT, and again mid-stream -> all outputs return to reset values; fetching restarts at RESET_PC.
- Preload fetch_count near saturation (force 32'hFFFF_FFFE) and run 3 cycles -> count reads 32'hFFFF_FFFF and stays there.
